// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch stage with a small output queue.
// Issues word reads to instruction memory, buffers the returned 16-bit
// instructions together with their PC, and presents the oldest one to the
// core over a valid/ready handshake. A redirect flushes the queue, restarts
// fetch at the new PC and discards responses still in flight. Halt stops new
// requests while in-flight responses still land and the core keeps draining.
// Build option: define FETCH_QUEUE_STATS_EN to add the stall_cnt[15:0] output.

module fetch_queue #(
  parameter int unsigned DEPTH    = 4,     // queue entries, power of 2, >= 2
  parameter int unsigned MAX_OUT  = 2,     // outstanding imem reads, 1..DEPTH
  parameter logic [15:0] RESET_PC = 16'h0  // first fetch address after reset
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
  } entry_t;

  state_e           state_q;
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [15:0]      rsp_pc_q,   rsp_pc_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [OUT_W-1:0] out_q,      out_d;
  logic [OUT_W-1:0] drop_q,     drop_d;
  entry_t           mem_q [DEPTH];

  logic issue;
  logic push;
  logic pop;

  // Request gating: only in RUN, and only while both the outstanding-read
  // credit and the free-slot credit (queued + in flight < DEPTH) allow it.
  // rst_n is folded in so no request is shown while reset is held.
  always_comb begin
    issue = rst_n && (state_q == RUN) && !hlt && !redirect
            && (32'(out_q) < MAX_OUT)
            && ((32'(count_q) + 32'(out_q)) < DEPTH);
  end

  // Queue handshake strobes: a response is kept only when nothing is pending
  // to be dropped and no redirect is flushing this cycle.
  always_comb begin
    push = imem_rsp_valid && !redirect && (drop_q == '0);
    pop  = (count_q != '0) && inst_ready;
  end

  // Next-state for PCs, queue pointers, occupancy and in-flight bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    out_d      = out_q;

    unique case ({issue, imem_rsp_valid})
      2'b10:   out_d = out_q + OUT_ONE;
      2'b01:   out_d = out_q - OUT_ONE;
      default: out_d = out_q;
    endcase

    if (issue) begin
      fetch_pc_d = fetch_pc_q + 16'd1;
    end

    if (redirect) begin
      // Flush everything; every read still in flight after this edge is stale.
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = imem_rsp_valid ? (out_q - OUT_ONE) : out_q;
    end else begin
      if (imem_rsp_valid) begin
        if (drop_q == '0) begin
          rsp_pc_d = rsp_pc_q + 16'd1;
        end else begin
          drop_d = drop_q - OUT_ONE;
        end
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers: PCs, pointers, occupancy and in-flight counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // Queue storage: written at the tail with the instruction and its PC.
  // NOTE: storage has no reset; an entry is only ever read after count_q shows it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{data: imem_rsp_data, pc: rsp_pc_q};
    end
  end

  // Fetch FSM: redirect wins, then halt, then the end of a drop window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else if (redirect) begin
      state_q <= (drop_d != '0) ? DRAIN : RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hlt) state_q <= HALT;
        end
        DRAIN: begin
          if (hlt)                 state_q <= HALT;
          else if (drop_d == '0)   state_q <= RUN;
        end
        HALT: begin
          if (!hlt) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stall_q, stall_d;

  // Stall counter: cycles where fetch may run but has no credit to issue.
  always_comb begin
    stall_d = stall_q;
    if (redirect) begin
      stall_d = '0;
    end else if ((state_q == RUN) && !hlt && !issue && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Stall counter register, saturating, cleared by reset and redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst       = mem_q[rd_ptr_q].data;
  assign inst_pc    = mem_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: a fixed-latency imem model answers the DUT's
// requests, a scoreboard holds the instructions the core should see in order,
// and a small reference of the fetch state predicts imem_req/imem_addr.
// A stimulus table covers the first cycles after reset; hand sequences cover
// back-pressure, redirect with stale reads, wrap-around and halt.

module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] stall_cnt;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH   (4),
    .MAX_OUT (2),
    .RESET_PC(16'h0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .hlt           (hlt)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  typedef enum int {M_RUN, M_DRAIN, M_HALT} mstate_e;

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [15:0] data;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic        hlt;
    logic        redirect;
    logic        ready;
    logic [15:0] rpc;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  localparam logic [15:0] XOR_KEY = 16'hA5A5;

  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  pend_t       pend[$];
  exp_t        sb[$];
  mstate_e     st_m;
  logic [15:0] fpc_m;
  logic [15:0] stall_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample 1 ns later,
  // compare against the reference, then advance the models.
  task automatic step(input logic h, input logic rd, input logic rdy, input logic [15:0] rpc,
                      output logic o_req, output logic [15:0] o_addr,
                      output logic o_valid, output logic [15:0] o_pc);
    bit      rsp;
    bit      exp_req;
    int      n_stale;
    pend_t   p;
    mstate_e pre;
    hlt         = h;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    rsp = (pend.size() != 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (pend[0].addr ^ XOR_KEY) : 16'h0000;
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = inst_valid;
    o_pc    = inst_pc;
    pre = st_m;
    exp_req = (pre == M_RUN) && !h && !rd && (pend.size() < 2) && ((sb.size() + pend.size()) < 4);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, fpc_m);
    check("inst_valid", inst_valid, sb.size() != 0);
`ifdef FETCH_QUEUE_STATS_EN
    check("stall_cnt", stall_cnt, stall_m);
    if (rd) stall_m = 16'h0000;
    else if ((pre == M_RUN) && !h && !exp_req && (stall_m != 16'hFFFF)) stall_m = stall_m + 16'd1;
`endif
    if (inst_valid && rdy && (sb.size() != 0)) begin
      check("inst_pc", inst_pc, sb[0].pc);
      check("inst", inst, sb[0].data);
      void'(sb.pop_front());
    end
    if (rsp) begin
      p = pend.pop_front();
      if (!p.stale && !rd) sb.push_back('{data: p.addr ^ XOR_KEY, pc: p.addr});
    end
    if (rd) begin
      sb.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      fpc_m = rpc;
    end else if (exp_req) begin
      fpc_m = fpc_m + 16'd1;
    end
    if (imem_req === 1'b1) pend.push_back('{addr: imem_addr, due: cyc + lat, stale: 1'b0});
    check("outstanding_cap", pend.size() <= 2, 1);
    n_stale = 0;
    foreach (pend[i]) if (pend[i].stale) n_stale++;
    if (rd) begin
      st_m = (n_stale != 0) ? M_DRAIN : M_RUN;
    end else begin
      case (pre)
        M_RUN:   if (h) st_m = M_HALT;
        M_DRAIN: if (h) st_m = M_HALT; else if (n_stale == 0) st_m = M_RUN;
        M_HALT:  if (!h) st_m = M_RUN;
        default: st_m = M_RUN;
      endcase
    end
    @(negedge clk);
    cyc++;
  endtask

  // Reset DUT and imem model together; checks outputs while reset is held.
  task automatic do_reset(input int latency);
    rst_n          = 1'b0;
    hlt            = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 16'h0000;
    inst_ready     = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 16'h0000;
    pend.delete();
    sb.delete();
    st_m    = M_RUN;
    fpc_m   = 16'h0000;
    stall_m = 16'h0000;
    lat     = latency;
    cyc     = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_imem_req", imem_req, 1'b0);
    check("reset_inst_valid", inst_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[8];
    logic        r;
    logic [15:0] a;
    logic        v;
    logic [15:0] pc;
    logic [15:0] pops[$];
    logic [15:0] wrap_exp[4];
    logic [15:0] first_addr;
    logic [15:0] first_pc;
    int          issued;
    int          gap;
    bit          found;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;

    // 1-cycle imem, core always ready: request k in cycle k, head is PC k-2.
    //          hlt   redir ready rpc       req   addr      valid pc
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h0001};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0002};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h0003};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h0004};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0007, 1'b1, 16'h0005};

    wrap_exp[0] = 16'hFFFE;
    wrap_exp[1] = 16'hFFFF;
    wrap_exp[2] = 16'h0000;
    wrap_exp[3] = 16'h0001;

    // Streaming after reset.
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].hlt, vecs[i].redirect, vecs[i].ready, vecs[i].rpc, r, a, v, pc);
      check($sformatf("vec%0d_req", i), r, vecs[i].exp_req);
      if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), a, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), v, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
    end

    // Back-pressure: queue fills at 4 entries, then drains and fetch resumes.
    do_reset(1);
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000, r, a, v, pc);
      if (r) issued++;
    end
    check("full_issued", issued, 4);
    check("full_req_low", r, 1'b0);
    check("full_head_valid", v, 1'b1);
    check("full_head_pc", pc, 16'h0000);
    pops.delete();
    found      = 1'b0;
    first_addr = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
      if (v) pops.push_back(pc);
      if (r && !found) begin
        found      = 1'b1;
        first_addr = a;
      end
    end
    check("resume_found", found, 1'b1);
    check("resume_addr", first_addr, 16'h0004);
    check("drain_pop_count_ge4", pops.size() >= 4, 1);
    for (int i = 0; i < 4 && i < pops.size(); i++) check($sformatf("drain_pop%0d", i), pops[i], i);

    // 3-cycle imem, redirect with reads 0005 and 0006 in flight.
    do_reset(3);
    step(1'b0, 1'b1, 1'b1, 16'h0001, r, a, v, pc);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (pend.size() == 2 && pend[0].addr == 16'h0005 && pend[1].addr == 16'h0006) found = 1'b1;
      else step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
    end
    check("pair_5_6_in_flight", found, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h0040, r, a, v, pc);
    gap        = 0;
    found      = 1'b0;
    first_addr = 16'h0000;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
      if (r) begin
        found      = 1'b1;
        first_addr = a;
      end else begin
        gap++;
      end
    end
    check("drain_ended", found, 1'b1);
    check("drain_cycles_le3", gap <= 3, 1);
    check("post_redirect_addr", first_addr, 16'h0040);
    found    = 1'b0;
    first_pc = 16'h0000;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
      if (v) begin
        found    = 1'b1;
        first_pc = pc;
      end
    end
    check("post_redirect_valid", found, 1'b1);
    check("post_redirect_pc", first_pc, 16'h0040);

    // Redirect in the same cycle as a response and a pop.
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
    step(1'b0, 1'b1, 1'b1, 16'h0100, r, a, v, pc);
    check("redir_pop_valid", v, 1'b1);
    check("redir_no_req", r, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
    check("redir_queue_empty", v, 1'b0);
    check("redir_next_req", r, 1'b1);
    check("redir_next_addr", a, 16'h0100);
    found    = 1'b0;
    first_pc = 16'h0000;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
      if (v) begin
        found    = 1'b1;
        first_pc = pc;
      end
    end
    check("redir_first_pc", first_pc, 16'h0100);

    // PC wrap-around from FFFE.
    do_reset(1);
    step(1'b0, 1'b1, 1'b1, 16'hFFFE, r, a, v, pc);
    pops.delete();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
      if (v) pops.push_back(pc);
    end
    check("wrap_pop_count_ge4", pops.size() >= 4, 1);
    for (int i = 0; i < 4 && i < pops.size(); i++) check($sformatf("wrap_pop%0d", i), pops[i], wrap_exp[i]);

    // Halt with two reads in flight: no new requests, both still delivered.
    do_reset(3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() == 2) found = 1'b1;
      else step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
    end
    check("halt_two_in_flight", found, 1'b1);
    issued = 0;
    pops.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
      if (r) issued++;
      if (v) pops.push_back(pc);
    end
    check("halt_no_req", issued, 0);
    check("halt_pop_count", pops.size(), 2);
    if (pops.size() == 2) begin
      check("halt_pop0", pops[0], 16'h0000);
      check("halt_pop1", pops[1], 16'h0001);
    end
    found      = 1'b0;
    first_addr = 16'h0000;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000, r, a, v, pc);
      if (r) begin
        found      = 1'b1;
        first_addr = a;
      end
    end
    check("unhalt_req", found, 1'b1);
    check("unhalt_addr", first_addr, 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
